// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Streams a contiguous region of a single-port, synchronous-read data RAM
// (1-cycle read latency) out through a valid/ready interface in address order.
// The address pointer wraps modulo 2^ADDR_WIDTH. A 2-entry output FIFO
// decouples the RAM read pipeline from consumer back-pressure.
// Optional feature macro: RAM_READER_CHECKSUM_EN adds a running sum of every
// accepted word. When it is undefined, o_checksum is tied to zero.

module ram_stream_reader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_baseAddress,
  input  logic [ADDR_WIDTH:0]   i_wordCount,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_memWrite,
  input  logic [DATA_WIDTH-1:0] i_readData,
  output logic [DATA_WIDTH-1:0] o_outData,
  output logic                  o_outValid,
  input  logic                  i_outReady,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [ADDR_WIDTH-1:0] r_pointer;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inFlight;

  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_rdIdx;
  logic                  r_wrIdx;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_startAccept;
  logic [2:0]            w_pending;
  logic [1:0]            w_occAfter;

  // The reader never writes the RAM.
  assign o_memWrite    = 1'b0;
  assign o_address     = r_pointer;

  // The FIFO head is presented straight from registers.
  assign o_outData     = r_fifo[r_rdIdx];
  assign o_outValid    = (r_count != 2'd0);

  assign w_pop         = o_outValid && i_outReady;
  assign w_startAccept = (r_state == S_IDLE) && i_start;

  // Words that will be held or arriving after this edge; a new read is only
  // issued while that leaves room in the 2-entry FIFO.
  assign w_pending     = {1'b0, r_count} + {2'b00, r_inFlight} - {2'b00, w_pop};
  assign w_issue       = (r_state == S_READ) && (w_pending < 3'd2);
  assign w_occAfter    = r_count - {1'b0, w_pop};

  // Sweep state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection and status outputs decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_wordCount == '0) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_READ;
          end
        end
      end
      S_READ: begin
        o_busy = 1'b1;
        if (w_issue && (r_remaining == (ADDR_WIDTH + 1)'(1))) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (!r_inFlight && (w_occAfter == 2'd0)) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Address pointer and remaining-word counter; a zero-length sweep leaves
  // the pointer untouched so the RAM address does not move.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pointer   <= '0;
      r_remaining <= '0;
      r_inFlight  <= 1'b0;
    end else begin
      r_inFlight <= w_issue;
      if (w_startAccept && (i_wordCount != '0)) begin
        r_pointer   <= i_baseAddress;
        r_remaining <= i_wordCount;
      end else if (w_issue) begin
        r_pointer   <= r_pointer + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Output FIFO: capture read data the cycle after issue, release on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rdIdx   <= 1'b0;
      r_wrIdx   <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (r_inFlight) begin
        r_fifo[r_wrIdx] <= i_readData;
        r_wrIdx         <= ~r_wrIdx;
      end
      if (w_pop) begin
        r_rdIdx <= ~r_rdIdx;
      end
      r_count <= r_count + {1'b0, r_inFlight} - {1'b0, w_pop};
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  assign o_checksum = r_checksum;

  // Running sum of accepted words, cleared when a sweep is started.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (w_startAccept) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + o_outData;
    end
  end
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
// Self-checking bench for ram_stream_reader with a behavioural RAM, a
// scoreboard queue of expected words and a decoupled output monitor.
// Build with RAM_READER_CHECKSUM_EN defined to check the running sum.

module tb_ram_stream_reader;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [AW:0]   wordCount = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] address;
  logic          memWrite;
  logic [DW-1:0] ramRd;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [DW-1:0] checksum;

  logic          tbLoad = 1'b1;
  logic          tbWe = 1'b0;
  logic [AW-1:0] tbAddr = '0;
  logic [DW-1:0] tbData = '0;
  logic          ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ram [DEPTH];

  int            checks = 0;
  int            errors = 0;
  int            accCount = 0;
  int            readyMode = 0;
  int            readyIdx = 0;
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] expSum = '0;
  logic [DW-1:0] monExp;
  logic          stalled = 1'b0;
  logic [DW-1:0] stallData = '0;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_baseAddress (baseAddr),
    .i_wordCount   (wordCount),
    .o_busy        (busy),
    .o_done        (done),
    .o_address     (address),
    .o_memWrite    (memWrite),
    .i_readData    (ramRd),
    .o_outData     (outData),
    .o_outValid    (outValid),
    .i_outReady    (outReady),
    .o_checksum    (checksum)
  );

  always #5 clk = ~clk;

  assign ramWe   = tbLoad ? tbWe : memWrite;
  assign ramAddr = tbLoad ? tbAddr : address;

  // Single-port RAM with synchronous read and one cycle of latency.
  always @(posedge clk) begin
    if (ramWe) ram[ramAddr] <= tbData;
    ramRd <= ram[ramAddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer ready pattern: always ready, 1-0-0 repeating, or random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      readyIdx++;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = ((readyIdx % 3) == 0);
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled word stays valid and unchanged.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stallValid", 64'(outValid), 64'd1);
        check("stallData", 64'(outData), 64'(stallData));
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWord actual=%0h required=none", outData);
        end else begin
          monExp = expQ.pop_front();
          check("streamWord", 64'(outData), 64'(monExp));
        end
        accCount++;
        stalled = 1'b0;
      end else if (outValid) begin
        stalled   = 1'b1;
        stallData = outData;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic writeRam(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tbLoad = 1'b1;
    tbAddr = a;
    tbData = d;
    tbWe   = 1'b1;
    @(posedge clk);
    #1;
    tbWe   = 1'b0;
    tbLoad = 1'b0;
  endtask

  // Queue the words the sweep must produce, then pulse Start for one edge.
  task automatic applyStimulus(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    expSum = '0;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      expQ.push_back(ram[a]);
      expSum = expSum + ram[a];
    end
    @(negedge clk);
    baseAddr  = b;
    wordCount = (AW + 1)'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulseStart(input logic [AW-1:0] b, input int n);
    @(negedge clk);
    baseAddr  = b;
    wordCount = (AW + 1)'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for Done, then check drain, checksum and status release.
  task automatic checkOutput(input string name, input int expCycles);
    int cycles;
    cycles = 0;
    while (!done && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s doneTimeout actual=%0d required=done", name, cycles);
    end else begin
      if (expCycles >= 0) check({name, "DoneCycle"}, 64'(cycles), 64'(expCycles));
      check({name, "Drained"}, 64'(expQ.size()), 64'd0);
`ifdef RAM_READER_CHECKSUM_EN
      check({name, "Checksum"}, 64'(checksum), 64'(expSum));
`else
      check({name, "Checksum"}, 64'(checksum), 64'd0);
`endif
      @(posedge clk);
      #1;
      check({name, "BusyDrop"}, 64'(busy), 64'd0);
      check({name, "DoneDrop"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] addrBefore;
    int            acc0;
    int            waitCycles;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rstBusy", 64'(busy), 64'd0);
    check("rstDone", 64'(done), 64'd0);
    check("rstAddress", 64'(address), 64'd0);
    check("rstMemWrite", 64'(memWrite), 64'd0);
    check("rstOutValid", 64'(outValid), 64'd0);
    check("rstOutData", 64'(outData), 64'd0);
    check("rstChecksum", 64'(checksum), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) writeRam(AW'(i), $urandom);
    for (int i = 0; i < 32; i++) writeRam(AW'(DEPTH - 32 + i), $urandom);

    // Basic four-word sweep with latency and throughput checks
    writeRam(14'd0, 32'd5);
    writeRam(14'd1, 32'd6);
    writeRam(14'd2, 32'd7);
    writeRam(14'd3, 32'd8);
    readyMode = 0;
    applyStimulus(14'd0, 4);
    check("t1Address", 64'(address), 64'd0);
    check("t1Busy", 64'(busy), 64'd1);
    check("t1ValidEarly0", 64'(outValid), 64'd0);
    @(posedge clk);
    #1;
    check("t1ValidEarly1", 64'(outValid), 64'd0);
    @(posedge clk);
    #1;
    check("t1FirstValid", 64'(outValid), 64'd1);
    check("t1FirstData", 64'(outData), 64'd5);
    checkOutput("t1", 4);
`ifdef RAM_READER_CHECKSUM_EN
    check("t1Sum26", 64'(expSum), 64'd26);
`endif

    // Zero-length sweep, plus a Start landing in the Done cycle
    addrBefore = address;
    applyStimulus(14'd9, 0);
    check("t2DoneNow", 64'(done), 64'd1);
    check("t2ValidLow", 64'(outValid), 64'd0);
    pulseStart(14'd5, 3);
    check("t2IgnoredBusy", 64'(busy), 64'd0);
    check("t2IgnoredDone", 64'(done), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t2StillIdle", 64'(busy), 64'd0);
    check("t2AddrHeld", 64'(address), 64'(addrBefore));

    // Address wrap across the top of the RAM
    writeRam(14'h3FFE, 32'hA0A0_000A);
    writeRam(14'h3FFF, 32'hB0B0_000B);
    writeRam(14'h0000, 32'hC0C0_000C);
    writeRam(14'h0001, 32'hD0D0_000D);
    applyStimulus(14'h3FFE, 4);
    checkOutput("t3", 6);

    // Eight words under a 1-0-0 ready pattern
    acc0 = accCount;
    readyIdx = -1;
    readyMode = 1;
    applyStimulus(14'd2, 8);
    checkOutput("t4", -1);
    check("t4Accepts", 64'(accCount - acc0), 64'd8);

    // Start pulsed mid-sweep must not disturb the stream
    readyMode = 0;
    applyStimulus(14'd10, 6);
    pulseStart(14'h3FE0, 3);
    checkOutput("t5", 7);

    // Reset after three of ten words, then a fresh two-word sweep
    acc0 = accCount;
    applyStimulus(14'd4, 10);
    waitCycles = 0;
    while ((accCount - acc0) < 3 && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    check("t6ThreeTaken", 64'(accCount - acc0), 64'd3);
    rst = 1'b1;
    #1;
    check("t6RstBusy", 64'(busy), 64'd0);
    check("t6RstDone", 64'(done), 64'd0);
    check("t6RstValid", 64'(outValid), 64'd0);
    check("t6RstAddress", 64'(address), 64'd0);
    check("t6RstData", 64'(outData), 64'd0);
    check("t6RstChecksum", 64'(checksum), 64'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(14'd0, 2);
    checkOutput("t6", 4);

    // Randomized sweeps near the wrap point with random back-pressure
    readyMode = 2;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(AW'(DEPTH - 32 + int'($urandom_range(0, 31))), int'($urandom_range(0, 20)));
      checkOutput("rand", -1);
    end

    readyMode = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
